cube_root: RTL
==============

// Module: cube_root
// PURPOSE
//  Integer cube root, the inverse of the pipelined cube block: o_root = floor(cbrt(i_x)).
//  Iterative shift/subtract datapath, 3 radicand bits per iteration.
//  Sits behind the NiosII custom-instruction port as a multi-cycle instruction (start/done).
//  Also used by software self-test to round-trip cubed values.
// PARAMETERS
//  WIDTH  32               radicand width; result width RW = (WIDTH+2)/3 (11 for 32)
//  ITER   (WIDTH+2)/3      iteration count; derived, never overridden
// PORTS
//  i_clk     in   1      single clock
//  i_srst    in   1      reset, synchronous, active-high
//  i_clkEn   in   1      clock enable; low freezes all state
//  i_start   in   1      start request, sampled when i_clkEn=1
//  i_x       in   WIDTH  radicand, captured on accepted start
//  o_busy    out  1      high while iterating
//  o_done    out  1      one enabled-cycle pulse: o_root valid
//  o_root    out  WIDTH  result, zero-extended from RW bits; held until next accept
// BEHAVIOUR
//  - Reset (i_srst=1, overrides i_clkEn): state=IDLE, o_busy=0, o_done=0, o_root=0, internals 0.
//  - States: IDLE -> CALC on accepted start; CALC -> DONE after ITER iterations; DONE -> IDLE
//    next enabled cycle, or DONE -> CALC if i_start=1 in that cycle (back-to-back).
//  - Accept: i_clkEn=1 && i_start=1 && state in {IDLE, DONE}. Captures rem<=i_x, y<=0, s<=3*(ITER-1).
//  - i_start while CALC: ignored; no restart, no effect on result.
//  - Iteration (one per enabled CALC cycle), s = 3*(ITER-1) down to 0 step 3:
//      y2 = y<<1; t = 3*y2*(y2+1)+1;
//      if ((rem >> s) >= t) { rem -= t << s; y <= y2+1; } else y <= y2;
//    Compare on rem>>s avoids wide operands; t fits in RW+RW+2 bits; subtraction never underflows.
//  - Latency: start accepted at enabled edge N -> ITER enabled edges of CALC -> o_done=1 and o_root
//    updated at edge N+ITER (12 enabled cycles incl. accept edge for WIDTH=32 ... i.e. done visible
//    ITER enabled cycles after accept). o_done deasserts on the next enabled edge.
//  - i_clkEn=0: no state, counter or output change; o_done stays asserted if already high.
//  - o_busy=1 exactly in CALC; o_done=1 exactly in DONE.
//  - Reset mid-CALC: aborts, no o_done, o_root=0.
//  - Boundaries: i_x=0 -> 0; i_x=2^WIDTH-1 -> 1625 (WIDTH=32); perfect cubes exact; n^3-1 -> n-1.
//  - All arithmetic unsigned; no X propagation from i_x when not accepted.
// STRUCTURE
//  - Package power_pkg: state enum {IDLE, CALC, DONE} (2-bit), function root_width(WIDTH),
//    constant CBRT_MAX_32 = 1625 for benches.
//  - Sub-module cube_root_step: combinational one iteration (rem, y, s) -> (rem_n, y_n);
//    top holds FSM, shift counter, registers.
// TESTING
//  1 i_x=27, start 1 cycle -> o_done after ITER enabled cycles, o_root=3; o_busy high throughout.
//  2 i_x=0 -> 0; i_x=26 -> 2; i_x=1000 -> 10; i_x=32'hFFFF_FFFF -> 1625; i_x=4291015624 -> 1624.
//  3 i_clkEn toggled 0/1 every other cycle during CALC -> same result, latency doubles, no lost done.
//  4 i_start pulsed again mid-CALC with i_x=8 -> ignored, first result returned; start in DONE
//    cycle with i_x=64 -> immediate CALC, second result 4.
//  5 i_srst at iteration 5 -> o_busy=0, o_done never pulses, o_root=0; next start runs cleanly.
//  6 Round-trip: random y in [0,1625] through cube block, feed result here -> o_root==y;
//    plus 10k random i_x checked vs. reference model floor(cbrt(x)).

Source files
------------

// File: rtl/power_pkg.sv
// Shared types and helpers for the power-function blocks (cube / cube root).
package power_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CBRT_MAX_32 = 1625;

  function automatic int root_width(input int width);
    return (width + 2) / 3;
  endfunction

endpackage

// File: rtl/cube_root_step.sv
// One shift/subtract cube-root iteration: tries to append a 1 bit to the partial root.
module cube_root_step #(
  parameter int WIDTH = 32,
  parameter int RW    = 11,
  parameter int SW    = 5
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [RW-1:0]    y_i,
  input  logic [SW-1:0]    s_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [RW-1:0]    y_o
);
  localparam int TW = 2 * RW + 2;
  localparam int CW = (TW > WIDTH) ? TW : WIDTH;

  logic [RW-1:0] y2;
  logic [CW-1:0] t;
  logic [CW-1:0] top;
  logic          ge;

  assign y2  = y_i << 1;
  // (y2+1)^3 - y2^3 = 3*y2*(y2+1) + 1; compared against the remainder's top bits only
  assign t   = CW'(3) * CW'(y2) * (CW'(y2) + CW'(1)) + CW'(1);
  assign top = CW'(rem_i >> s_i);
  assign ge  = top >= t;

  // t<<s only matters when ge, and then it is bounded by rem_i, so truncation is safe
  assign rem_o = ge ? rem_i - WIDTH'(t << s_i) : rem_i;
  assign y_o   = ge ? (y2 | RW'(1)) : y2;

endmodule

// File: rtl/cube_root.sv
// Multi-cycle integer cube root, floor(cbrt(i_x)), 3 radicand bits per enabled cycle.
module cube_root
  import power_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_clkEn,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_x,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_root
);
  localparam int RW   = root_width(WIDTH);
  localparam int ITER = RW;
  localparam int SMAX = 3 * (ITER - 1);
  localparam int SW   = $clog2(SMAX + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, rem_n;
  logic [RW-1:0]    y_q, y_d, y_n;
  logic [SW-1:0]    s_q, s_d;
  logic [RW-1:0]    root_q, root_d;

  cube_root_step #(.WIDTH(WIDTH), .RW(RW), .SW(SW)) u_step (
    .rem_i (rem_q),
    .y_i   (y_q),
    .s_i   (s_q),
    .rem_o (rem_n),
    .y_o   (y_n)
  );

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      y_q     <= '0;
      s_q     <= '0;
      root_q  <= '0;
    end else if (i_clkEn) begin
      state_q <= state_d;
      rem_q   <= rem_d;
      y_q     <= y_d;
      s_q     <= s_d;
      root_q  <= root_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    y_d     = y_q;
    s_d     = s_q;
    root_d  = root_q;
    case (state_q)
      CALC: begin
        rem_d = rem_n;
        y_d   = y_n;
        if (s_q == '0) begin
          state_d = DONE;
          root_d  = y_n;
        end else begin
          s_d = s_q - SW'(3);
        end
      end
      IDLE, DONE: begin
        // DONE returns to IDLE unless a back-to-back start is accepted
        state_d = IDLE;
        if (i_start) begin
          state_d = CALC;
          rem_d   = i_x;
          y_d     = '0;
          s_d     = SW'(SMAX);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q == CALC);
    o_done = (state_q == DONE);
    o_root = WIDTH'(root_q);
  end

endmodule
